// File: rtl/temp_sampler.sv
// temp_sampler: periodic SYSMON die-temperature reader for the fan controller.
// Issues a DRP read every SAMPLE_DIV cycles, box-car averages 2^AVG_LOG2 samples,
// raises a hysteretic over-temperature alarm and flags a sensor fault on DRP timeout.
//
// Ports:
//   clk_in_100        system clock (100 MHz)
//   rst_n_in          asynchronous active-low reset
//   drp_den_out       DRP enable, one-cycle pulse per read
//   drp_daddr_out     DRP address (DRP_ADDR)
//   drp_dwe_out       DRP write enable (always 0)
//   drp_drdy_in       DRP read-data-ready pulse
//   drp_do_in         DRP read data
//   raw_temp_out      latest averaged raw temperature code (0xFFFF after reset)
//   sample_valid_out  one-cycle pulse, the cycle after raw_temp_out updates
//   temp_alarm_out    over-temperature or sensor-fault alarm
//   sensor_err_out    DRP timeout fault
module temp_sampler #(
  parameter int unsigned SAMPLE_DIV     = 100000,
  parameter logic [6:0]  DRP_ADDR       = 7'h00,
  parameter int unsigned AVG_LOG2       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] ALARM_SET_RAW  = 16'hB6A7,
  parameter logic [15:0] ALARM_CLR_RAW  = 16'hB41B
) (
  input  logic        clk_in_100,
  input  logic        rst_n_in,
  output logic        drp_den_out,
  output logic [6:0]  drp_daddr_out,
  output logic        drp_dwe_out,
  input  logic        drp_drdy_in,
  input  logic [15:0] drp_do_in,
  output logic [15:0] raw_temp_out,
  output logic        sample_valid_out,
  output logic        temp_alarm_out,
  output logic        sensor_err_out
);

  localparam int unsigned DivW = $clog2(SAMPLE_DIV);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SumW = 16 + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;

  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StAccum, StFault} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     sample_q, sample_d;
  logic [SumW-1:0] sum_q, sum_d, sum_next;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     raw_q, raw_d, avg;
  logic            avg_done_q, avg_done_d;
  logic            valid_q;
  logic            alarm_q, alarm_d;
  logic            err_q, err_d;
  logic            have_avg_q, have_avg_d;
  logic            tick;

  // Free-running period counter; the tick is the wrap cycle.
  assign tick = (div_q == DivLast);

  always_ff @(posedge clk_in_100 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign sum_next = sum_q + SumW'(sample_q);
  assign avg      = sum_next[AVG_LOG2 +: 16];

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    sample_d   = sample_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    raw_d      = raw_q;
    avg_done_d = 1'b0;
    alarm_d    = alarm_q;
    err_d      = err_q;
    have_avg_d = have_avg_q;

    unique case (state_q)
      StIdle: begin
        // Ticks arriving outside idle are simply lost.
        if (tick) state_d = StReq;
      end
      StReq: begin
        // Count this cycle so the fault lands TIMEOUT_CYCLES after the enable pulse.
        tmo_d   = TmoW'(1);
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + TmoW'(1);
        if (drp_drdy_in) begin
          sample_d = drp_do_in;
          err_d    = 1'b0;
          state_d  = StAccum;
        end else if (tmo_q == TmoLast) begin
          // Fault outputs are registered on entry so they appear with the timeout.
          err_d   = 1'b1;
          alarm_d = 1'b1;
          state_d = StFault;
        end
      end
      StAccum: begin
        if (cnt_q == CntLast) begin
          raw_d      = avg;
          avg_done_d = 1'b1;
          sum_d      = '0;
          cnt_d      = '0;
          have_avg_d = 1'b1;
          if (!have_avg_q) begin
            alarm_d = (avg >= ALARM_SET_RAW);
          end else if (avg >= ALARM_SET_RAW) begin
            alarm_d = 1'b1;
          end else if (avg < ALARM_CLR_RAW) begin
            alarm_d = 1'b0;
          end
        end else begin
          sum_d = sum_next;
          cnt_d = cnt_q + CntW'(1);
        end
        state_d = StIdle;
      end
      StFault: begin
        sum_d      = '0;
        cnt_d      = '0;
        have_avg_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in_100 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      sample_q   <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      raw_q      <= 16'hFFFF;
      avg_done_q <= 1'b0;
      valid_q    <= 1'b0;
      alarm_q    <= 1'b1;
      err_q      <= 1'b0;
      have_avg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      sample_q   <= sample_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      raw_q      <= raw_d;
      avg_done_q <= avg_done_d;
      valid_q    <= avg_done_q;
      alarm_q    <= alarm_d;
      err_q      <= err_d;
      have_avg_q <= have_avg_d;
    end
  end

  assign drp_den_out      = (state_q == StReq);
  assign drp_daddr_out    = DRP_ADDR;
  assign drp_dwe_out      = 1'b0;
  assign raw_temp_out     = raw_q;
  assign sample_valid_out = valid_q;
  // A dead sensor always reads as hot.
  assign temp_alarm_out   = alarm_q | err_q;
  assign sensor_err_out   = err_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Bench for temp_sampler: DRP responder, event-scheduled reference model and
// per-cycle comparison, plus literal checks at the end of each scenario.
module tb_temp_sampler;

  localparam int unsigned SampleDiv = 16;
  localparam int unsigned AvgLog2   = 3;
  localparam int          Timeout   = 255;
  localparam logic [15:0] SetRaw    = 16'hB6A7;
  localparam logic [15:0] ClrRaw    = 16'hB41B;

  logic        clk;
  logic        rst_n = 1'b0;
  logic        drp_den, drp_dwe, sample_valid, temp_alarm, sensor_err;
  logic [6:0]  drp_daddr;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do = '0;
  logic [15:0] raw_temp;

  temp_sampler #(
    .SAMPLE_DIV(SampleDiv)
  ) dut (
    .clk_in_100      (clk),
    .rst_n_in        (rst_n),
    .drp_den_out     (drp_den),
    .drp_daddr_out   (drp_daddr),
    .drp_dwe_out     (drp_dwe),
    .drp_drdy_in     (drp_drdy),
    .drp_do_in       (drp_do),
    .raw_temp_out    (raw_temp),
    .sample_valid_out(sample_valid),
    .temp_alarm_out  (temp_alarm),
    .sensor_err_out  (sensor_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sensor samples accepted by the DUT schedule future output events.
  int unsigned m_sum = 0;
  int          m_n = 0;
  logic [15:0] m_raw = 16'hFFFF;
  logic        m_alarm = 1'b1, m_err = 1'b0, m_have = 1'b0;
  int          ev_err_clr = -1, ev_raw = -1, ev_valid = -1, ev_fault = -1;
  logic [15:0] ev_raw_val = '0;

  task automatic model_accept(input logic [15:0] d);
    ev_err_clr = cyc + 1;
    m_sum += d;
    m_n++;
    if (m_n == (1 << AvgLog2)) begin
      ev_raw_val = 16'(m_sum >> AvgLog2);
      ev_raw     = cyc + 2;
      ev_valid   = cyc + 3;
      m_sum      = 0;
      m_n        = 0;
    end
  endtask

  // DRP responder
  int          lat = 2;
  bit          no_resp = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;
  bit          inj_req = 0;
  logic [15:0] inj_data = '0;
  int          n_den = 0;
  logic [15:0] dq[$];

  initial forever begin
    @(negedge clk);
    drp_drdy = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (inj_req) begin
        drp_drdy = 1'b1;
        drp_do   = inj_data;
        inj_req  = 0;
      end else if (pend) begin
        if (pend_cnt == 1) begin
          drp_drdy = 1'b1;
          drp_do   = pend_data;
          pend     = 0;
          model_accept(pend_data);
        end else begin
          pend_cnt--;
        end
      end
      if (drp_den) begin
        chk("den_while_busy", 32'(pend), 0);
        n_den++;
        if (no_resp) begin
          ev_fault = cyc + Timeout;
        end else begin
          pend      = 1;
          pend_cnt  = lat;
          pend_data = (dq.size() > 0) ? dq.pop_front() : 16'h9000;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  int last_den = -1;
  bit prev_den = 0;
  int exp_period = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_sum = 0; m_n = 0; m_raw = 16'hFFFF; m_alarm = 1'b1; m_err = 1'b0; m_have = 1'b0;
      ev_err_clr = -1; ev_raw = -1; ev_valid = -1; ev_fault = -1;
      last_den = -1; prev_den = 0;
    end else begin
      if (cyc == ev_err_clr) m_err = 1'b0;
      if (cyc == ev_raw) begin
        m_raw = ev_raw_val;
        if (!m_have) m_alarm = (ev_raw_val >= SetRaw);
        else if (ev_raw_val >= SetRaw) m_alarm = 1'b1;
        else if (ev_raw_val < ClrRaw) m_alarm = 1'b0;
        m_have = 1'b1;
      end
      if (cyc == ev_fault) begin
        m_err = 1'b1; m_alarm = 1'b1; m_sum = 0; m_n = 0; m_have = 1'b0;
      end
    end
    chk("raw_temp", raw_temp, m_raw);
    chk("sample_valid", sample_valid, 32'(rst_n && cyc == ev_valid));
    chk("temp_alarm", temp_alarm, 32'(m_alarm | m_err));
    chk("sensor_err", sensor_err, m_err);
    chk("drp_dwe", drp_dwe, 0);
    chk("drp_daddr", drp_daddr, 0);
    if (prev_den) chk("den_width", drp_den, 0);
    if (drp_den && last_den >= 0) begin
      chk("den_period_mod", (cyc - last_den) % SampleDiv, 0);
      if (exp_period != 0) chk("den_period", cyc - last_den, exp_period);
    end
    if (drp_den) last_den = cyc;
    prev_den = drp_den;
  end

  task automatic push(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) dq.push_back(d);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (k < 400) begin
      @(negedge clk);
      if (sample_valid) break;
      k++;
    end
    chk({name, "_valid_seen"}, 32'(k < 400), 1);
  endtask

  task automatic wait_err(input logic val, input string name);
    int k = 0;
    while (k < 600) begin
      @(negedge clk);
      if (sensor_err == val) break;
      k++;
    end
    chk(name, sensor_err, val);
  endtask

  task automatic wait_den(input string name);
    int n0 = n_den;
    int k = 0;
    while (k < 100 && n_den == n0) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(n_den != n0), 1);
  endtask

  task automatic inj(input logic [15:0] d);
    inj_data = d;
    inj_req  = 1;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_raw"}, raw_temp, 16'hFFFF);
    chk({tag, "_alarm"}, temp_alarm, 1);
    chk({tag, "_err"}, sensor_err, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_den"}, drp_den, 0);
  endtask

  initial begin
    int n0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    exp_period = SampleDiv;
    wait_valid("avg_9000");
    chk("avg_9000_raw", raw_temp, 16'h9000);
    chk("avg_9000_alarm", temp_alarm, 0);

    push(16'd46700, 4);
    push(16'd46800, 4);
    wait_valid("avg_46750");
    chk("avg_46750_raw", raw_temp, 16'd46750);
    chk("avg_46750_alarm", temp_alarm, 0);

    push(16'd46760, 8);
    wait_valid("avg_46760");
    chk("avg_46760_raw", raw_temp, 16'd46760);
    chk("avg_46760_alarm", temp_alarm, 1);

    push(16'd46200, 8);
    wait_valid("avg_46200");
    chk("avg_46200_raw", raw_temp, 16'd46200);
    chk("avg_46200_alarm", temp_alarm, 1);

    push(16'd46000, 8);
    wait_valid("avg_46000");
    chk("avg_46000_raw", raw_temp, 16'd46000);
    chk("avg_46000_alarm", temp_alarm, 0);

    // Dead sensor
    exp_period = 0;
    no_resp = 1;
    wait_err(1'b1, "fault_err_set");
    chk("fault_alarm", temp_alarm, 1);
    chk("fault_raw_hold", raw_temp, 16'd46000);
    no_resp = 0;
    wait_err(1'b0, "fault_err_clr");
    chk("recover_alarm_held", temp_alarm, 1);
    wait_valid("avg_recover");
    chk("avg_recover_raw", raw_temp, 16'h9000);
    chk("avg_recover_alarm", temp_alarm, 0);

    // Slow DRP: ticks land in WAIT and must be dropped
    lat = 20;
    wait_den("slow_first_den");
    exp_period = 2 * SampleDiv;
    n0 = n_den;
    repeat (200) @(negedge clk);
    exp_period = 0;
    chk("slow_den_count", 32'((n_den - n0) >= 5), 1);

    // Reset in the middle of a read, then stray and spurious drdy pulses in idle
    wait_den("rst_wait_den");
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    lat = 2;
    #1 chk_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    inj(16'hFFFF);
    repeat (2) @(negedge clk);
    inj(16'h0000);
    repeat (2) @(negedge clk);
    inj(16'h0000);
    wait_valid("avg_after_rst");
    chk("avg_after_rst_raw", raw_temp, 16'h9000);
    chk("avg_after_rst_alarm", temp_alarm, 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/temp_sampler.md
Name: temp_sampler

Overview:
- Upstream stage of the fan controller: periodically reads the on-chip SYSMON die-temperature register over the DRP port.
- Box-car averages 2^AVG_LOG2 samples and presents the result as the raw temperature code the fan controller converts to centi-degrees.
- Generates a hysteretic over-temperature alarm and a sensor-fault flag; both drive the controller's alarm input so the fan runs full-on when hot or when the sensor is dead.

Parameters:
- SAMPLE_DIV, 100000: clk_in_100 cycles between read requests (1 ms); minimum 16.
- DRP_ADDR, 7'h00: DRP address of the temperature status register.
- AVG_LOG2, 3: log2 of samples per average (0..6).
- TIMEOUT_CYCLES, 255: cycles to wait for drp_drdy_in before declaring a fault.
- ALARM_SET_RAW, 16'hB6A7: raw code (≈85.00 C) at or above which the alarm sets.
- ALARM_CLR_RAW, 16'hB41B: raw code (≈80.00 C) below which the alarm clears; must be < ALARM_SET_RAW.

Ports:
- clk_in_100  in  1  system clock, 100 MHz.
- rst_n_in  in  1  reset; one clock, reset asynchronous, active-low.
- drp_den_out  out  1  DRP enable; one-cycle pulse per read.
- drp_daddr_out  out  7  DRP address; held at DRP_ADDR.
- drp_dwe_out  out  1  DRP write enable; tied 0.
- drp_drdy_in  in  1  DRP read-data-ready pulse.
- drp_do_in  in  16  DRP read data.
- raw_temp_out  out  16  latest averaged raw code.
- sample_valid_out  out  1  one-cycle pulse when raw_temp_out updates.
- temp_alarm_out  out  1  over-temperature or sensor-fault alarm.
- sensor_err_out  out  1  DRP timeout fault.

Behaviour:
- Reset values: drp_den_out=0, drp_dwe_out=0, raw_temp_out=16'hFFFF (fail-safe hot), sample_valid_out=0, temp_alarm_out=1, sensor_err_out=0.
- Reset clears the period counter, accumulator, sample count, timeout counter, first-average flag and FSM state (IDLE). Assertion mid-read abandons the transaction; a late drp_drdy_in after reset is ignored.
- Period counter: counts 0..SAMPLE_DIV-1 and wraps. The tick fires on the wrap.
  - Tick in IDLE: start a read.
  - Tick in any other state: dropped, with no queueing.
- FSM:
  - IDLE -> REQ on tick.
  - REQ: drp_den_out=1 for exactly this cycle -> WAIT.
  - WAIT: timeout counter increments each cycle.
    - drp_drdy_in=1: capture drp_do_in -> ACCUM.
    - Timeout counter reaches TIMEOUT_CYCLES without drdy -> FAULT.
  - ACCUM: sum += sample; count += 1.
    - If count reaches 2^AVG_LOG2: raw_temp_out <= sum >> AVG_LOG2 (truncating); sample_valid_out=1 on the following cycle; clear sum and count.
    - Returns to IDLE.
  - FAULT: sensor_err_out<=1; temp_alarm_out<=1; discard partial sum and count; -> IDLE. raw_temp_out holds its value.
- drp_drdy_in outside WAIT is ignored.
- Accumulator width: 16+AVG_LOG2 bits; no overflow possible.
- Fault recovery: sensor_err_out clears on the next successful DRP read, not the next average.
- Alarm evaluation (only on a new average, same cycle raw_temp_out updates):
  - First average after reset or after a fault: alarm = (avg >= ALARM_SET_RAW).
  - Subsequent averages: set if avg >= ALARM_SET_RAW; clear if avg < ALARM_CLR_RAW; otherwise hold.
  - While sensor_err_out=1, temp_alarm_out is forced 1 regardless.
- Latency: drdy-to-raw_temp_out update = 2 cycles on the completing sample; sample_valid_out is high 3 cycles after that drdy.

Test Plan:
- Reset, DRP model returns 16'h9000 with 2-cycle drdy latency, AVG_LOG2=3:
  - den pulses every SAMPLE_DIV cycles, each exactly 1 cycle wide, addr=7'h00, dwe=0.
  - After the 8th read: raw_temp_out=16'h9000, one sample_valid_out pulse, temp_alarm_out 1->0.
- Samples 46700 x4, 46800 x4: average 46750 < SET -> alarm stays 0.
- Then 8x46760: alarm sets.
- Then 8x46200: alarm holds 1.
- Then 8x46000: alarm clears.
- DRP model never asserts drdy:
  - sensor_err_out=1 and temp_alarm_out=1 exactly TIMEOUT_CYCLES cycles after the den pulse.
  - raw_temp_out unchanged.
  - Next good read clears sensor_err_out; the first subsequent average of 16'h9000 clears the alarm.
- Set SAMPLE_DIV=16 and drdy latency 20 cycles: ticks during WAIT are dropped, with exactly one den per completed transaction.
- Assert rst_n_in during WAIT, then send a stray drdy with data 16'hFFFF:
  - Outputs return to reset values asynchronously.
  - The stray drdy is not accumulated; the next average equals the model value.
- Spurious drdy pulses in IDLE with data 16'h0000: no change to sum, count or outputs.
